// File: rtl/updown_counter_n_pkg.sv
// Shared constants and helpers for the up/down counter family.
package counter_pkg;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic DIR_UP    = 1'b1;

   // Register width able to hold 0..n-1, never less than one bit.
   function automatic int unsigned clog2_safe(input longint unsigned n);
      if (n <= 64'd2) return 1;
      return 32'($clog2(n));
   endfunction

endpackage

// File: rtl/updown_counter_n_if.sv
// Control and status bundle between board-side logic and the counter.
interface updown_counter_n_if #(
   parameter int unsigned WIDTH = 3
);
   logic             en;
   logic             dir;
   logic             mode;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             tick;
   logic             tc;
   logic             wrap;

   modport master (
      output en, dir, mode, load, load_val,
      input  count, tick, tc, wrap
   );

   modport slave (
      input  en, dir, mode, load, load_val,
      output count, tick, tc, wrap
   );
endinterface

// File: rtl/updown_counter_n_tick_prescaler.sv
// Clock-enable generator: tick is high one cycle in every DIV, replacing a derived clock.
module tick_prescaler
   import counter_pkg::*;
#(
   parameter int unsigned DIV = 1
) (
   input  logic clkin,
   input  logic reset,
   output logic tick
);

   localparam int unsigned     PW     = clog2_safe(64'(DIV));
   localparam logic [PW-1:0]   P_LAST = PW'(DIV - 1);

   logic [PW-1:0] p_q;
   logic [PW-1:0] p_d;

   always_comb begin
      p_d = p_q + PW'(1);
      if (p_q == P_LAST) p_d = '0;
   end

   always_ff @(posedge clkin) begin
      if (reset) p_q <= '0;
      else       p_q <= p_d;
   end

   assign tick = (p_q == P_LAST);

endmodule

// File: rtl/updown_counter_n.sv
// Parametrised up/down counter with prescaled count enable, load, wrap/saturate and flags.
module updown_counter_n
   import counter_pkg::*;
#(
   parameter int unsigned      WIDTH   = 3,
   parameter longint unsigned  MODULUS = 64'(1) << WIDTH,
   parameter int unsigned      DIV     = 1
) (
   input  logic                 clkin,
   input  logic                 reset,
   updown_counter_n_if.slave    bus
);

   localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 64'd1);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             wrap_q;
   logic             wrap_d;
   logic             tick;

   tick_prescaler #(.DIV(DIV)) u_prescaler (
      .clkin (clkin),
      .reset (reset),
      .tick  (tick)
   );

   // Load beats step beats hold; wrap flags only a boundary crossing.
   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (bus.load) begin
         count_d = (bus.load_val > CNT_MAX) ? CNT_MAX : bus.load_val;
      end else if (tick && bus.en) begin
         if (bus.dir == DIR_UP) begin
            if (count_q != CNT_MAX) begin
               count_d = count_q + WIDTH'(1);
            end else if (bus.mode == MODE_WRAP) begin
               count_d = '0;
               wrap_d  = 1'b1;
            end
         end else begin
            if (count_q != '0) begin
               count_d = count_q - WIDTH'(1);
            end else if (bus.mode == MODE_WRAP) begin
               count_d = CNT_MAX;
               wrap_d  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clkin) begin
      if (reset) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   assign bus.count = count_q;
   assign bus.wrap  = wrap_q;
   assign bus.tick  = tick;
   assign bus.tc    = (bus.dir == DIR_UP) ? (count_q == CNT_MAX) : (count_q == '0);

endmodule

// File: tb/tb_updown_counter_n.sv
// Directed bench: dut_a is WIDTH=3/DIV=4 (full range), dut_b is WIDTH=3/MODULUS=6/DIV=1.
module tb_updown_counter_n;

   logic clk;
   logic rst_a;
   logic rst_b;
   int   n_checks;
   int   n_fail;

   updown_counter_n_if #(.WIDTH(3)) ia ();
   updown_counter_n_if #(.WIDTH(3)) ib ();

   updown_counter_n #(.WIDTH(3), .MODULUS(64'd8), .DIV(4)) dut_a (
      .clkin (clk),
      .reset (rst_a),
      .bus   (ia)
   );

   updown_counter_n #(.WIDTH(3), .MODULUS(64'd6), .DIV(1)) dut_b (
      .clkin (clk),
      .reset (rst_b),
      .bus   (ib)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic clk_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_a = 1'b1; rst_b = 1'b1;
      ia.en = 1'b1; ia.dir = 1'b1; ia.mode = 1'b0; ia.load = 1'b1; ia.load_val = 3'd5;
      ib.en = 1'b1; ib.dir = 1'b1; ib.mode = 1'b0; ib.load = 1'b1; ib.load_val = 3'd5;
      clk_edge();
      clk_edge();
      n_checks++;
      if (ia.count !== 3'd0) begin n_fail++; $display("FAIL reset_count_a: got %0d expected 0", ia.count); end
      n_checks++;
      if (ib.count !== 3'd0) begin n_fail++; $display("FAIL reset_count_b: got %0d expected 0", ib.count); end
      n_checks++;
      if (ia.wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap_a: got %b expected 0", ia.wrap); end
      n_checks++;
      if (ia.tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick_a: got %b expected 0", ia.tick); end
      n_checks++;
      if (ib.tick !== 1'b1) begin n_fail++; $display("FAIL reset_tick_b: got %b expected 1", ib.tick); end
      n_checks++;
      if (ia.tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc_up: got %b expected 0", ia.tc); end
      ia.dir = 1'b0;
      #1;
      n_checks++;
      if (ia.tc !== 1'b1) begin n_fail++; $display("FAIL reset_tc_down: got %b expected 1", ia.tc); end
      ia.load = 1'b0; ib.load = 1'b0; ib.en = 1'b0;
      rst_b = 1'b0;
   endtask

   task automatic test_up_wrap();
      logic [2:0] exp;
      rst_a = 1'b1;
      clk_edge();
      rst_a = 1'b0; ia.load = 1'b0; ia.en = 1'b1; ia.dir = 1'b1; ia.mode = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         clk_edge();
         exp = 3'((k / 4) % 8);
         n_checks++;
         if (ia.count !== exp) begin n_fail++; $display("FAIL up_count k=%0d: got %0d expected %0d", k, ia.count, exp); end
         n_checks++;
         if (ia.wrap !== (k == 32)) begin n_fail++; $display("FAIL up_wrap k=%0d: got %b expected %b", k, ia.wrap, (k == 32)); end
         n_checks++;
         if (ia.tc !== (exp == 3'd7)) begin n_fail++; $display("FAIL up_tc k=%0d: got %b expected %b", k, ia.tc, (exp == 3'd7)); end
         n_checks++;
         if (ia.tick !== ((k % 4) == 3)) begin n_fail++; $display("FAIL up_tick k=%0d: got %b expected %b", k, ia.tick, ((k % 4) == 3)); end
      end
   endtask

   task automatic test_down_wrap();
      logic [2:0] exp;
      ia.dir = 1'b0;
      #1;
      n_checks++;
      if (ia.tc !== 1'b1) begin n_fail++; $display("FAIL down_tc_start: got %b expected 1", ia.tc); end
      for (int k = 1; k <= 12; k++) begin
         clk_edge();
         exp = (k < 4) ? 3'd0 : 3'((8 - k / 4) % 8);
         n_checks++;
         if (ia.count !== exp) begin n_fail++; $display("FAIL down_count k=%0d: got %0d expected %0d", k, ia.count, exp); end
         n_checks++;
         if (ia.wrap !== (k == 4)) begin n_fail++; $display("FAIL down_wrap k=%0d: got %b expected %b", k, ia.wrap, (k == 4)); end
         n_checks++;
         if (ia.tc !== (exp == 3'd0)) begin n_fail++; $display("FAIL down_tc k=%0d: got %b expected %b", k, ia.tc, (exp == 3'd0)); end
      end
   endtask

   task automatic test_saturate();
      logic [2:0] exp;
      rst_a = 1'b1;
      clk_edge();
      rst_a = 1'b0; ia.load = 1'b1; ia.load_val = 3'd5; ia.en = 1'b1; ia.dir = 1'b1; ia.mode = 1'b1;
      clk_edge();
      ia.load = 1'b0;
      for (int e = 2; e <= 16; e++) begin
         clk_edge();
         exp = (e < 4) ? 3'd5 : (e < 8) ? 3'd6 : 3'd7;
         n_checks++;
         if (ia.count !== exp) begin n_fail++; $display("FAIL sat_count e=%0d: got %0d expected %0d", e, ia.count, exp); end
         n_checks++;
         if (ia.wrap !== 1'b0) begin n_fail++; $display("FAIL sat_wrap e=%0d: got %b expected 0", e, ia.wrap); end
      end
      n_checks++;
      if (ia.tc !== 1'b1) begin n_fail++; $display("FAIL sat_tc_top: got %b expected 1", ia.tc); end
      ia.dir = 1'b0;
      #1;
      n_checks++;
      if (ia.tc !== 1'b0) begin n_fail++; $display("FAIL sat_tc_dirflip: got %b expected 0", ia.tc); end
      for (int e = 17; e <= 20; e++) begin
         clk_edge();
         exp = (e < 20) ? 3'd7 : 3'd6;
         n_checks++;
         if (ia.count !== exp) begin n_fail++; $display("FAIL sat_down e=%0d: got %0d expected %0d", e, ia.count, exp); end
      end
      ia.mode = 1'b0;
   endtask

   task automatic test_load();
      logic [2:0] exp;
      rst_a = 1'b1;
      clk_edge();
      rst_a = 1'b0; ia.en = 1'b0; ia.dir = 1'b1; ia.mode = 1'b0; ia.load = 1'b1; ia.load_val = 3'd3;
      clk_edge();
      n_checks++;
      if (ia.count !== 3'd3) begin n_fail++; $display("FAIL load_notick: got %0d expected 3", ia.count); end
      ia.load = 1'b0;
      clk_edge();
      clk_edge();
      n_checks++;
      if (ia.tick !== 1'b1) begin n_fail++; $display("FAIL load_tick_phase: got %b expected 1", ia.tick); end
      ia.load = 1'b1; ia.load_val = 3'd6; ia.en = 1'b1;
      clk_edge();
      n_checks++;
      if (ia.count !== 3'd6) begin n_fail++; $display("FAIL load_vs_step: got %0d expected 6", ia.count); end
      n_checks++;
      if (ia.wrap !== 1'b0) begin n_fail++; $display("FAIL load_wrap: got %b expected 0", ia.wrap); end
      ia.load = 1'b0;
      for (int e = 5; e <= 8; e++) begin
         clk_edge();
         exp = (e < 8) ? 3'd6 : 3'd7;
         n_checks++;
         if (ia.count !== exp) begin n_fail++; $display("FAIL load_after e=%0d: got %0d expected %0d", e, ia.count, exp); end
      end
   endtask

   task automatic test_modulus();
      logic [2:0] exp;
      rst_b = 1'b1;
      clk_edge();
      rst_b = 1'b0; ib.en = 1'b1; ib.dir = 1'b1; ib.mode = 1'b0; ib.load = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         clk_edge();
         exp = 3'(k % 6);
         n_checks++;
         if (ib.count !== exp) begin n_fail++; $display("FAIL mod_count k=%0d: got %0d expected %0d", k, ib.count, exp); end
         n_checks++;
         if (ib.wrap !== (k == 6)) begin n_fail++; $display("FAIL mod_wrap k=%0d: got %b expected %b", k, ib.wrap, (k == 6)); end
         n_checks++;
         if (ib.tc !== (exp == 3'd5)) begin n_fail++; $display("FAIL mod_tc k=%0d: got %b expected %b", k, ib.tc, (exp == 3'd5)); end
      end
      ib.load = 1'b1; ib.load_val = 3'd7;
      clk_edge();
      n_checks++;
      if (ib.count !== 3'd5) begin n_fail++; $display("FAIL mod_clamp: got %0d expected 5", ib.count); end
      ib.load = 1'b0; ib.dir = 1'b0;
      clk_edge();
      n_checks++;
      if (ib.count !== 3'd4) begin n_fail++; $display("FAIL mod_down: got %0d expected 4", ib.count); end
      ib.load = 1'b1; ib.load_val = 3'd0;
      clk_edge();
      ib.load = 1'b0;
      clk_edge();
      n_checks++;
      if (ib.count !== 3'd5) begin n_fail++; $display("FAIL mod_down_wrap: got %0d expected 5", ib.count); end
      n_checks++;
      if (ib.wrap !== 1'b1) begin n_fail++; $display("FAIL mod_down_wrapflag: got %b expected 1", ib.wrap); end
      clk_edge();
      n_checks++;
      if (ib.count !== 3'd4) begin n_fail++; $display("FAIL mod_down_after: got %0d expected 4", ib.count); end
      n_checks++;
      if (ib.wrap !== 1'b0) begin n_fail++; $display("FAIL mod_wrap_clear: got %b expected 0", ib.wrap); end
      ib.en = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [2:0] exp;
      rst_a = 1'b1;
      clk_edge();
      rst_a = 1'b0; ia.load = 1'b0; ia.en = 1'b1; ia.dir = 1'b1; ia.mode = 1'b0;
      for (int k = 1; k <= 18; k++) clk_edge();
      n_checks++;
      if (ia.count !== 3'd4) begin n_fail++; $display("FAIL mid_precount: got %0d expected 4", ia.count); end
      rst_a = 1'b1;
      clk_edge();
      n_checks++;
      if (ia.count !== 3'd0) begin n_fail++; $display("FAIL mid_reset_count: got %0d expected 0", ia.count); end
      n_checks++;
      if (ia.tick !== 1'b0) begin n_fail++; $display("FAIL mid_reset_tick: got %b expected 0", ia.tick); end
      rst_a = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         clk_edge();
         exp = (k < 4) ? 3'd0 : 3'd1;
         n_checks++;
         if (ia.count !== exp) begin n_fail++; $display("FAIL mid_restart k=%0d: got %0d expected %0d", k, ia.count, exp); end
      end
      rst_a = 1'b1; ia.load = 1'b1; ia.load_val = 3'd6;
      clk_edge();
      n_checks++;
      if (ia.count !== 3'd0) begin n_fail++; $display("FAIL mid_reset_over_load: got %0d expected 0", ia.count); end
      rst_a = 1'b0; ia.load = 1'b0; ia.en = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_saturate();
      test_load();
      test_modulus();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
